// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port RiSC-16 data memory between the
//            load/store stage (port 0) and the debug/program-loader port
//            (port 1). Round-robin arbitration with a bounded lock that lets
//            a port keep ownership for back-to-back bursts.
// Ports    : clk, rst_n            - clock, async active-low reset
//            reqN/weN/lockN        - request, store enable, keep-ownership
//            addrN/wdataN          - word address and store data
//            gntN                  - access accepted this cycle (comb)
//            rvalidN/rdataN        - registered load return, one-cycle pulse
//            mem_sw/mem_addr/
//            mem_wdata/mem_rdata   - memory side (rdata comb from addr)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_sw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int          LCW        = $clog2(MAX_LOCK) + 1;
  localparam logic [31:0] MAX_LOCK_U = MAX_LOCK;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;
  logic [DW-1:0]  rdata0_q, rdata0_d;
  logic [DW-1:0]  rdata1_q, rdata1_d;
  logic           lock_room;

  // Another locked access is allowed only if it would not exceed MAX_LOCK.
  assign lock_room = (32'(lock_cnt_q) + 32'd1) < MAX_LOCK_U;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt0) begin
      if (lock0 && lock_room) begin
        state_d    = S_OWN0;
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end else begin
        state_d    = S_IDLE;
        lock_cnt_d = '0;
        rr_ptr_d   = 1'b1;
      end
    end else if (gnt1) begin
      if (lock1 && lock_room) begin
        state_d    = S_OWN1;
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end else begin
        state_d    = S_IDLE;
        lock_cnt_d = '0;
        rr_ptr_d   = 1'b0;
      end
    end else begin
      // No grant while owning means the owner dropped req: release the lock.
      case (state_q)
        S_OWN0: begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
          rr_ptr_d   = 1'b1;
        end
        S_OWN1: begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
          rr_ptr_d   = 1'b0;
        end
        S_IDLE:  state_d = S_IDLE;
        default: begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic: grants, memory drive, load capture
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // Grants are suppressed while reset is held so no strobe leaks out.
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          gnt0 = req0 && (!req1 || !rr_ptr_q);
          gnt1 = req1 && (!req0 ||  rr_ptr_q);
        end
        S_OWN0:  gnt0 = req0;
        S_OWN1:  gnt1 = req1;
        default: ;
      endcase
    end

    mem_sw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_sw    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_sw    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end

    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed bench for dmem_arbiter with a small behavioural memory
//            (256 words, initial contents 16'h1000 + index).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_sw;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(16), .DW(16), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_sw(mem_sw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_sw) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requester inputs shortly after the falling edge.
  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1);
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // ---- reset with both requesting ----
    drive(1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0);
    drive(1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);

    // ---- round robin: release reset in the first grant cycle ----
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rr_c0_gnt0", gnt0, 1);
    check("rr_c0_gnt1", gnt1, 0);
    check("rr_c0_addr", mem_addr, 16'h0010);
    drive(1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0);
    check("rr_c1_gnt1", gnt1, 1);
    check("rr_c1_gnt0", gnt0, 0);
    check("rr_c1_rvalid0", rvalid0, 1);
    check("rr_c1_rdata0", rdata0, 16'h1010);
    check("rr_c1_rvalid1", rvalid1, 0);
    drive(1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0);
    check("rr_c2_gnt0", gnt0, 1);
    check("rr_c2_rvalid1", rvalid1, 1);
    check("rr_c2_rdata1", rdata1, 16'h1020);
    check("rr_c2_rvalid0", rvalid0, 0);
    drive(1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0);
    check("rr_c3_gnt1", gnt1, 1);
    check("rr_c3_rvalid0", rvalid0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rr_c4_rvalid1", rvalid1, 1);
    check("rr_c4_rdata1", rdata1, 16'h1020);
    check("idle_gnt", {gnt0, gnt1}, 0);
    check("idle_sw", mem_sw, 0);
    check("idle_addr", mem_addr, 0);
    check("idle_wdata", mem_wdata, 0);

    // ---- store then load of the same address ----
    drive(0, 0, 0, 0, 0, 1, 1, 0, 16'h0040, 16'hBEEF);
    check("st_gnt1", gnt1, 1);
    check("st_sw", mem_sw, 1);
    check("st_addr", mem_addr, 16'h0040);
    check("st_wdata", mem_wdata, 16'hBEEF);
    drive(1, 0, 0, 16'h0040, 0, 0, 0, 0, 0, 0);
    check("ld_gnt0", gnt0, 1);
    check("ld_sw", mem_sw, 0);
    check("st_no_rvalid1", rvalid1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ld_rvalid0", rvalid0, 1);
    check("ld_rdata0", rdata0, 16'hBEEF);
    check("ld_sw_after", mem_sw, 0);

    // ---- lock burst: 8 locked grants to port 0, then port 1 ----
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 1, 16'h0010 + 16'(k), 0, (k != 0), 0, 0, 16'h0020, 0);
      if (k < 8) begin
        check($sformatf("lk_gnt0_%0d", k), gnt0, 1);
        check($sformatf("lk_gnt1_%0d", k), gnt1, 0);
      end else begin
        check("lk_gnt0_end", gnt0, 0);
        check("lk_gnt1_end", gnt1, 1);
      end
      if (k > 0) check($sformatf("lk_rdata0_%0d", k), rdata0, 16'h1010 + 16'(k - 1));
    end

    // ---- port 1 locks 3 accesses then drops req ----
    for (int k = 0; k < 3; k++) begin
      drive((k != 0), 0, 0, 16'h0011, 0, 1, 0, 1, 16'h0030 + 16'(k), 0);
      check($sformatf("rel_gnt1_%0d", k), gnt1, 1);
      check($sformatf("rel_gnt0_%0d", k), gnt0, 0);
    end
    drive(1, 0, 0, 16'h0011, 0, 0, 0, 0, 0, 0);
    check("rel_bubble", {gnt0, gnt1}, 0);
    check("rel_rdata1", rdata1, 16'h1032);
    drive(1, 0, 0, 16'h0011, 0, 0, 0, 0, 0, 0);
    check("rel_gnt0", gnt0, 1);

    // ---- mid-burst reset during locked port 0 reads ----
    for (int k = 0; k < 3; k++) drive(1, 0, 1, 16'h0050, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mr_rvalid0_pre", rvalid0, 1);
    rst_n = 1'b0;
    #1;
    check("mr_rvalid0_async", rvalid0, 0);
    check("mr_rdata0_async", rdata0, 0);
    check("mr_sw", mem_sw, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mr_sw_hold", mem_sw, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 1, 16'h0060, 0, 1, 0, 0, 16'h0070, 0);
      if (k < 8) check($sformatf("mr_gnt0_%0d", k), {gnt0, gnt1}, 2'b10);
      else       check("mr_gnt1_end", {gnt0, gnt1}, 2'b01);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mr_rdata1_end", rdata1, 16'h1070);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
